// File: rtl/outbound_fifo_pkg.sv
// Shared constants, RAM word layout and write-FSM states for the outbound store-and-forward buffer.
package outbound_fifo_pkg;

  localparam int DEPTH  = 8192;
  localparam int ADDR_W = 13;
  localparam int PTR_W  = ADDR_W + 1;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_word_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_t;

endpackage

// File: rtl/outbound_fifo_skid.sv
// 2-entry skid buffer between the LSRAM read port and the outbound stream.
// Latency: out_vld one cycle after a push. Backpressure: in_rdy low only when both entries are held and nothing pops.
// used: entries still held once this cycle's pop completes.
module outbound_fifo_skid
  import outbound_fifo_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       in_vld,
  input  logic [8:0] in_dat,
  output logic       in_rdy,
  output logic       out_vld,
  output logic [8:0] out_dat,
  input  logic       out_rdy,
  output logic [1:0] used
);

  fifo_word_t ent [2];
  logic       head;
  logic [1:0] cnt;
  logic       push;
  logic       pop;

  assign pop     = out_vld & out_rdy;
  assign in_rdy  = (cnt != 2'd2) | pop;
  assign push    = in_vld & in_rdy;
  assign out_vld = (cnt != 2'd0);
  assign out_dat = ent[head];
  // Credit reflects the pop so the read side can issue every cycle while draining.
  assign used    = cnt - {1'b0, pop};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt  <= 2'd0;
      head <= 1'b0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop) head <= ~head;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) ent[head ^ cnt[0]] <= fifo_word_t'(in_dat);
  end

endmodule

// File: rtl/outbound_fifo_ctrl.sv
// Store-and-forward controller for the outbound 8192x9 LSRAM; OUTBOUND_FIFO_STATS_EN builds drop/tx counters.
// Latency: out_valid 3 cycles after the edge accepting in_last on an empty buffer; 1 byte/cycle sustained.
// Backpressure: never on input (overflow drops the packet); output holds on out_ready low.
module outbound_fifo_ctrl
  import outbound_fifo_pkg::*;
#(
  parameter int DEPTH  = outbound_fifo_pkg::DEPTH,
  parameter int ADDR_W = outbound_fifo_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  input  logic              in_abort,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        ram_wd,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_ren,
  input  logic [8:0]        ram_rd,
  output logic [ADDR_W:0]   pkt_count,
  output logic [ADDR_W:0]   free_words,
  output logic              drop_pulse,
  output logic [15:0]       drop_count,
  output logic [15:0]       tx_count
);

  localparam int            PW      = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  wr_state_t     state_q, state_d;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, pkt_start;
  logic          commit_pend;
  logic          rd_pend;
  logic          accept, full;
  logic          wr_do, drop_do, commit_do;
  logic          tx_done;
  logic          skid_in_rdy;
  logic [1:0]    skid_used;
  logic [2:0]    credit_sum;
  logic [8:0]    skid_out_dat;

  assign in_ready = ~RESET;
  assign accept   = in_valid & in_ready;
  assign full     = (wr_ptr - rd_ptr) == DEPTH_P;

  always_comb begin
    state_d   = state_q;
    wr_do     = 1'b0;
    drop_do   = 1'b0;
    commit_do = 1'b0;
    case (state_q)
      ACCEPT: begin
        if (accept) begin
          if (in_abort) begin
            drop_do = 1'b1;
          end else if (full) begin
            drop_do = 1'b1;
            if (!in_last) state_d = DROP;
          end else begin
            wr_do     = 1'b1;
            commit_do = in_last;
          end
        end
      end
      DROP: begin
        if (accept && in_last) state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // pkt_start tracks the commit point immediately so a drop restores correctly
  // even while commit_ptr is still one edge behind the RAM write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ACCEPT;
      wr_ptr      <= '0;
      pkt_start   <= '0;
      commit_ptr  <= '0;
      commit_pend <= 1'b0;
      ram_wen     <= 1'b0;
      ram_waddr   <= '0;
      ram_wd      <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      state_q     <= state_d;
      commit_pend <= commit_do;
      drop_pulse  <= drop_do;
      ram_wen     <= wr_do;
      if (wr_do) begin
        ram_waddr <= wr_ptr[ADDR_W-1:0];
        ram_wd    <= {in_last, in_data};
      end
      if (drop_do)    wr_ptr <= pkt_start;
      else if (wr_do) wr_ptr <= wr_ptr + 1'b1;
      if (commit_do)   pkt_start  <= wr_ptr + 1'b1;
      if (commit_pend) commit_ptr <= pkt_start;
    end
  end

  assign credit_sum = {1'b0, skid_used} + {2'b00, rd_pend};
  assign ram_ren    = ~RESET & (rd_ptr != commit_ptr) & (credit_sum < 3'd2) & skid_in_rdy;
  assign ram_raddr  = rd_ptr[ADDR_W-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= ram_ren;
      if (ram_ren) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  outbound_fifo_skid u_skid (
    .CLK     (CLK),
    .RESET   (RESET),
    .in_vld  (rd_pend),
    .in_dat  (ram_rd),
    .in_rdy  (skid_in_rdy),
    .out_vld (out_valid),
    .out_dat (skid_out_dat),
    .out_rdy (out_ready),
    .used    (skid_used)
  );

  assign out_last = skid_out_dat[8];
  assign out_data = skid_out_dat[7:0];
  assign tx_done  = out_valid & out_ready & out_last;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pkt_count <= '0;
    end else if (commit_pend && !tx_done) begin
      pkt_count <= pkt_count + 1'b1;
    end else if (tx_done && !commit_pend) begin
      pkt_count <= pkt_count - 1'b1;
    end
  end

  assign free_words = DEPTH_P - (wr_ptr - rd_ptr);

`ifdef OUTBOUND_FIFO_STATS_EN
  logic [15:0] drop_cnt, tx_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      drop_cnt <= '0;
      tx_cnt   <= '0;
    end else begin
      if (drop_do && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (tx_done && tx_cnt != 16'hFFFF)   tx_cnt   <= tx_cnt + 16'd1;
    end
  end

  assign drop_count = drop_cnt;
  assign tx_count   = tx_cnt;
`else
  assign drop_count = 16'd0;
  assign tx_count   = 16'd0;
`endif

endmodule
